float_multiply: RTL and testbench

FLOAT_MULTIPLY -- requirements
Module: float_multiply

---
 rtl/float_pkg.sv | 38 +++
 rtl/float_multiply_if.sv | 38 +++
 rtl/float_normalize_truncate.sv | 67 ++++++
 rtl/float_multiply.sv | 119 +++++++++++
 tb/tb_float_multiply.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/float_pkg.sv
// Shared helpers for the small-float multiplier: exponent bias,
// operand classification and the canonical NaN fraction pattern.
package float_pkg;

   typedef enum logic [1:0] {
      FC_ZERO,
      FC_NORM,
      FC_INF,
      FC_NAN
   } fclass_t;

   function automatic int bias(int e);
      return (1 << (e - 1)) - 1;
   endfunction

   // Denormals are flushed, so an all-zero exponent is zero
   // whatever the fraction holds.
   function automatic fclass_t classify(logic exp_zero,
                                        logic exp_ones,
                                        logic frac_nz);
      fclass_t c;
      if (exp_zero)
         c = FC_ZERO;
      else if (exp_ones && frac_nz)
         c = FC_NAN;
      else if (exp_ones)
         c = FC_INF;
      else
         c = FC_NORM;
      return c;
   endfunction

   // Quiet-NaN fraction: MSB set, rest clear (w <= 32).
   function automatic logic [31:0] nan_frac(int w);
      return 32'd1 << (w - 1);
   endfunction

endpackage

// File: rtl/float_multiply_if.sv
// Operand/result bundle of the multiplier.
// master drives operands (in_*) and reads the result; slave is the DUT side.
interface float_multiply_if #(
   parameter int EXP_IN_A      = 3,
   parameter int FRAC_IN_A     = 2,
   parameter int EXP_IN_B      = 3,
   parameter int FRAC_IN_B     = 2,
   parameter int EXP_OUT       = 4,
   parameter int FRAC_OUT      = 5,
   parameter int TRAILING_BITS = 2
);
   logic                     in_a_sign;
   logic [EXP_IN_A-1:0]      in_a_exp;
   logic [FRAC_IN_A-1:0]     in_a_frac;
   logic                     in_b_sign;
   logic [EXP_IN_B-1:0]      in_b_exp;
   logic [FRAC_IN_B-1:0]     in_b_frac;
   logic                     out_sign;
   logic [EXP_OUT-1:0]       out_exp;
   logic [FRAC_OUT-1:0]      out_frac;
   logic [TRAILING_BITS-1:0] trailing_bits;
   logic                     sticky_bit;
   logic                     is_nan;

   modport master (
      output in_a_sign, in_a_exp, in_a_frac,
      output in_b_sign, in_b_exp, in_b_frac,
      input  out_sign, out_exp, out_frac,
      input  trailing_bits, sticky_bit, is_nan
   );

   modport slave (
      input  in_a_sign, in_a_exp, in_a_frac,
      input  in_b_sign, in_b_exp, in_b_frac,
      output out_sign, out_exp, out_frac,
      output trailing_bits, sticky_bit, is_nan
   );
endinterface

// File: rtl/float_normalize_truncate.sv
// Normalizes a finite significand product, rebiases the exponent,
// truncates the fraction and extracts trailing/sticky bits.
// Ports: a_exp/b_exp biased operand exponents, prod = (1.fa)*(1.fb);
// res_exp/frac/trail/sticky finite result, clamped to zero or inf.
module float_normalize_truncate
   import float_pkg::*;
#(
   parameter int EXP_IN_A      = 3,
   parameter int FRAC_IN_A     = 2,
   parameter int EXP_IN_B      = 3,
   parameter int FRAC_IN_B     = 2,
   parameter int EXP_OUT       = 4,
   parameter int FRAC_OUT      = 5,
   parameter int TRAILING_BITS = 2
) (
   input  logic [EXP_IN_A-1:0]            a_exp,
   input  logic [EXP_IN_B-1:0]            b_exp,
   input  logic [FRAC_IN_A+FRAC_IN_B+1:0] prod,
   output logic [EXP_OUT-1:0]             res_exp,
   output logic [FRAC_OUT-1:0]            frac,
   output logic [TRAILING_BITS-1:0]       trail,
   output logic                           sticky
);
   localparam int NW = FRAC_IN_A + FRAC_IN_B + 1;
   localparam int TB = TRAILING_BITS;
   localparam int XW = EXP_OUT + 3;
   localparam int RB = NW - FRAC_OUT;
   localparam int SB = (RB > TB) ? RB - TB : 0;

   localparam logic [NW-1:0] SMASK = NW'((64'd1 << SB) - 64'd1);
   localparam logic [XW-1:0] BSUM =
      XW'(bias(EXP_IN_A) + bias(EXP_IN_B));
   localparam logic [XW-1:0] OVF =
      XW'(bias(EXP_IN_A) + bias(EXP_IN_B) + (1 << EXP_OUT) - 1);
   localparam logic [XW-1:0] BO = XW'(bias(EXP_OUT));

   logic           hi;
   logic [NW-1:0]  nfrac;
   logic [NW+TB-1:0] ext;
   logic [XW-1:0]  esum;

   // esum is the out exponent plus both input biases, kept
   // non-negative so the range checks need no signed math.
   always_comb begin
      hi    = prod[NW];
      nfrac = hi ? prod[NW-1:0] : {prod[NW-2:0], 1'b0};
      esum  = XW'(a_exp) + XW'(b_exp) + XW'(hi) + BO;
      ext   = {nfrac, {TB{1'b0}}};

      res_exp = '0;
      frac    = '0;
      trail   = '0;
      sticky  = 1'b0;

      if (esum <= BSUM) begin
         res_exp = '0;
      end else if (esum >= OVF) begin
         res_exp = '1;
      end else begin
         res_exp = EXP_OUT'(esum - BSUM);
         frac    = ext[NW+TB-1 -: FRAC_OUT];
         trail   = ext[NW+TB-1-FRAC_OUT -: TB];
         sticky  = |(nfrac & SMASK);
      end
   end

endmodule

// File: rtl/float_multiply.sv
// Single-cycle small-float multiplier with registered result.
// Ports: clock, reset (async, active low), bus (slave): operand
// fields in, product fields, trailing/sticky bits and is_nan out.
module float_multiply
   import float_pkg::*;
#(
   parameter int EXP_IN_A      = 3,
   parameter int FRAC_IN_A     = 2,
   parameter int EXP_IN_B      = 3,
   parameter int FRAC_IN_B     = 2,
   parameter int EXP_OUT       = 4,
   parameter int FRAC_OUT      = 5,
   parameter int TRAILING_BITS = 2
) (
   input logic        clock,
   input logic        reset,
   float_multiply_if.slave bus
);
   localparam int PW = FRAC_IN_A + FRAC_IN_B + 2;

   fclass_t                  ca;
   fclass_t                  cb;
   logic [PW-1:0]            prod;
   logic [EXP_OUT-1:0]       n_exp;
   logic [FRAC_OUT-1:0]      n_frac;
   logic [TRAILING_BITS-1:0] n_trail;
   logic                     n_sticky;
   logic                     r_nan;
   logic                     r_inf;
   logic                     r_zero;
   logic [EXP_OUT-1:0]       d_exp;
   logic [FRAC_OUT-1:0]      d_frac;
   logic [TRAILING_BITS-1:0] d_trail;
   logic                     d_sticky;
   logic                     d_nan;

   assign ca = classify(bus.in_a_exp == '0, &bus.in_a_exp,
                        |bus.in_a_frac);
   assign cb = classify(bus.in_b_exp == '0, &bus.in_b_exp,
                        |bus.in_b_frac);

   assign prod = PW'({1'b1, bus.in_a_frac})
               * PW'({1'b1, bus.in_b_frac});

   float_normalize_truncate #(
      .EXP_IN_A      (EXP_IN_A),
      .FRAC_IN_A     (FRAC_IN_A),
      .EXP_IN_B      (EXP_IN_B),
      .FRAC_IN_B     (FRAC_IN_B),
      .EXP_OUT       (EXP_OUT),
      .FRAC_OUT      (FRAC_OUT),
      .TRAILING_BITS (TRAILING_BITS)
   ) u_norm (
      .a_exp   (bus.in_a_exp),
      .b_exp   (bus.in_b_exp),
      .prod    (prod),
      .res_exp (n_exp),
      .frac    (n_frac),
      .trail   (n_trail),
      .sticky  (n_sticky)
   );

   // inf*zero lands in r_nan, so the three flags never overlap.
   always_comb begin
      r_nan  = (ca == FC_NAN) || (cb == FC_NAN)
            || (ca == FC_INF && cb == FC_ZERO)
            || (ca == FC_ZERO && cb == FC_INF);
      r_inf  = !r_nan && (ca == FC_INF || cb == FC_INF);
      r_zero = !r_nan && (ca == FC_ZERO || cb == FC_ZERO);

      d_exp    = n_exp;
      d_frac   = n_frac;
      d_trail  = n_trail;
      d_sticky = n_sticky;
      d_nan    = 1'b0;

      unique case (1'b1)
         r_nan: begin
            d_exp    = '1;
            d_frac   = FRAC_OUT'(nan_frac(FRAC_OUT));
            d_trail  = '0;
            d_sticky = 1'b0;
            d_nan    = 1'b1;
         end
         r_inf: begin
            d_exp    = '1;
            d_frac   = '0;
            d_trail  = '0;
            d_sticky = 1'b0;
         end
         r_zero: begin
            d_exp    = '0;
            d_frac   = '0;
            d_trail  = '0;
            d_sticky = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bus.out_sign      <= 1'b0;
         bus.out_exp       <= '0;
         bus.out_frac      <= '0;
         bus.trailing_bits <= '0;
         bus.sticky_bit    <= 1'b0;
         bus.is_nan        <= 1'b0;
      end else begin
         bus.out_sign      <= bus.in_a_sign ^ bus.in_b_sign;
         bus.out_exp       <= d_exp;
         bus.out_frac      <= d_frac;
         bus.trailing_bits <= d_trail;
         bus.sticky_bit    <= d_sticky;
         bus.is_nan        <= d_nan;
      end
   end

endmodule

// File: tb/tb_float_multiply.sv
// Scoreboard bench for float_multiply: default DUT plus a FRAC_OUT=2
// DUT, random and directed operands against an arithmetic model.
module tb_float_multiply;

   typedef struct packed {
      logic       sign;
      logic [3:0] exp;
      logic [7:0] frac;
      logic [1:0] trail;
      logic       sticky;
      logic       nan;
   } res_t;

   typedef struct packed {
      res_t       r0;
      res_t       r1;
      logic [1:0] lit_sel;
      res_t       lit;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   int   compared = 0;
   int   mismatched = 0;
   exp_t q[$];

   always #5 clock = ~clock;

   float_multiply_if bus0 ();
   float_multiply_if #(.FRAC_OUT(2)) bus1 ();

   float_multiply dut0 (
      .clock (clock),
      .reset (reset),
      .bus   (bus0)
   );

   float_multiply #(.FRAC_OUT(2)) dut1 (
      .clock (clock),
      .reset (reset),
      .bus   (bus1)
   );

   function automatic res_t mk(logic s, logic [3:0] e, logic [7:0] f,
                               logic [1:0] t, logic st, logic n);
      res_t r;
      r.sign = s; r.exp = e; r.frac = f;
      r.trail = t; r.sticky = st; r.nan = n;
      return r;
   endfunction

   // Value-level model: decode, multiply integer significands,
   // locate the leading one, then slice the exact fraction.
   function automatic res_t model(int sa, int ea, int fa,
                                  int sb, int eb, int fb, int fo);
      res_t r;
      bit az, ai, an, bz, bi, bn;
      int p, n, be, rem, sh;
      longint fx;
      r = '0;
      r.sign = 1'(sa ^ sb);
      az = (ea == 0); ai = (ea == 7 && fa == 0); an = (ea == 7 && fa != 0);
      bz = (eb == 0); bi = (eb == 7 && fb == 0); bn = (eb == 7 && fb != 0);
      if (an || bn || (ai && bz) || (az && bi)) begin
         r.exp = 4'd15; r.frac = 8'(1 << (fo - 1)); r.nan = 1'b1;
         return r;
      end
      if (ai || bi) begin
         r.exp = 4'd15;
         return r;
      end
      if (az || bz) return r;
      p = (4 + fa) * (4 + fb);
      n = 0;
      while ((p >> (n + 1)) != 0) n++;
      be = (ea - 3) + (eb - 3) + (n - 4) + 7;
      if (be <= 0) return r;
      if (be >= 15) begin
         r.exp = 4'd15;
         return r;
      end
      rem = p - (1 << n);
      fx = longint'(rem << (5 - n)) << 8;
      sh = 13 - fo;
      r.exp = 4'(be);
      r.frac = 8'(fx >> sh);
      r.trail = 2'((fx >> (sh - 2)) & 3);
      r.sticky = ((fx & ((64'sd1 <<< (sh - 2)) - 1)) != 0);
      return r;
   endfunction

   function automatic res_t got0();
      return mk(bus0.out_sign, bus0.out_exp, 8'(bus0.out_frac),
                bus0.trailing_bits, bus0.sticky_bit, bus0.is_nan);
   endfunction

   function automatic res_t got1();
      return mk(bus1.out_sign, bus1.out_exp, 8'(bus1.out_frac),
                bus1.trailing_bits, bus1.sticky_bit, bus1.is_nan);
   endfunction

   task automatic check(string name, res_t got, res_t want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("FAIL %s: got s%b e%0d f%b t%b st%b n%b, want s%b e%0d f%b t%b st%b n%b",
                  name, got.sign, got.exp, got.frac, got.trail,
                  got.sticky, got.nan, want.sign, want.exp, want.frac,
                  want.trail, want.sticky, want.nan);
      end
   endtask

   task automatic apply(int sa, int ea, int fa, int sb, int eb, int fb,
                        logic [1:0] lit_sel, res_t lit);
      exp_t e;
      bus0.in_a_sign = 1'(sa); bus0.in_a_exp = 3'(ea); bus0.in_a_frac = 2'(fa);
      bus0.in_b_sign = 1'(sb); bus0.in_b_exp = 3'(eb); bus0.in_b_frac = 2'(fb);
      bus1.in_a_sign = 1'(sa); bus1.in_a_exp = 3'(ea); bus1.in_a_frac = 2'(fa);
      bus1.in_b_sign = 1'(sb); bus1.in_b_exp = 3'(eb); bus1.in_b_frac = 2'(fb);
      e.r0 = model(sa, ea, fa, sb, eb, fb, 5);
      e.r1 = model(sa, ea, fa, sb, eb, fb, 2);
      e.lit_sel = lit_sel;
      e.lit = lit;
      q.push_back(e);
   endtask

   task automatic drive(int sa, int ea, int fa, int sb, int eb, int fb,
                        logic [1:0] lit_sel, res_t lit);
      @(negedge clock);
      apply(sa, ea, fa, sb, eb, fb, lit_sel, lit);
   endtask

   task automatic drive_rand();
      drive(int'($urandom_range(1)), int'($urandom_range(7)),
            int'($urandom_range(3)), int'($urandom_range(1)),
            int'($urandom_range(7)), int'($urandom_range(3)),
            2'd0, '0);
   endtask

   always @(posedge clock) begin
      exp_t e;
      #1;
      if (reset !== 1'b1) begin
         check("rst_hold0", got0(), '0);
         check("rst_hold1", got1(), '0);
      end else if (q.size() > 0) begin
         e = q.pop_front();
         check("dut0", got0(), e.r0);
         check("dut1", got1(), e.r1);
         if (e.lit_sel == 2'd1) check("lit0", got0(), e.lit);
         if (e.lit_sel == 2'd2) check("lit1", got1(), e.lit);
      end
   end

   initial begin
      int waited;
      reset = 1'b1;
      apply(0, 3, 0, 0, 3, 0, 2'd0, '0);
      q.delete();
      #1 reset = 1'b0;
      #1;
      check("reset0", got0(), '0);
      check("reset1", got1(), '0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;

      drive(0, 3, 2, 1, 3, 2, 2'd1, mk(1, 4'd8, 8'b00100, 2'b00, 0, 0));
      drive(0, 6, 3, 0, 6, 3, 2'd1, mk(0, 4'd14, 8'b10001, 2'b00, 0, 0));
      drive(0, 1, 0, 0, 1, 0, 2'd1, mk(0, 4'd3, 8'b00000, 2'b00, 0, 0));
      drive(0, 7, 0, 0, 0, 1, 2'd1, mk(0, 4'd15, 8'b10000, 2'b00, 0, 1));
      drive(1, 7, 1, 0, 3, 0, 2'd1, mk(1, 4'd15, 8'b10000, 2'b00, 0, 1));
      drive(0, 3, 3, 0, 3, 3, 2'd2, mk(0, 4'd8, 8'b10, 2'b00, 1, 0));
      drive(1, 7, 0, 1, 6, 3, 2'd1, mk(0, 4'd15, 8'b00000, 2'b00, 0, 0));
      drive(1, 0, 3, 0, 6, 1, 2'd1, mk(1, 4'd0, 8'b00000, 2'b00, 0, 0));

      for (int i = 0; i < 300; i++) drive_rand();

      drive(0, 5, 1, 0, 2, 2, 2'd0, '0);
      #1 reset = 1'b0;
      q.delete();
      #1;
      check("midrst0", got0(), '0);
      check("midrst1", got1(), '0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      apply(0, 6, 3, 1, 6, 3, 2'd1, mk(1, 4'd14, 8'b10001, 2'b00, 0, 0));

      for (int i = 0; i < 60; i++) drive_rand();

      waited = 0;
      while (q.size() > 0 && waited < 10) begin
         @(posedge clock);
         waited++;
      end
      #2;
      compared++;
      if (q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: %0d results outstanding, want 0", q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
